// File: rtl/aes_hex_line_formatter.sv
// aes_hex_line_formatter: formats each input word as one fixed-width ASCII hex line.
// Leading zero nibbles print as spaces and each line ends with EOL_CHAR.
module aes_hex_line_formatter #(
    parameter int          DATA_WIDTH     = 128,
    parameter int          FIELD_CHARS    = 32,
    parameter int          SUPPRESS_ZEROS = 1,
    parameter logic [7:0]  EOL_CHAR       = 8'h0A
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    input  logic [DATA_WIDTH-1:0] InData_DI,
    input  logic                  InValid_SI,
    output logic                  InReady_SO,
    output logic [7:0]            OutChar_DO,
    output logic                  OutValid_SO,
    input  logic                  OutReady_SI,
    output logic                  Busy_SO
);
    localparam int N  = DATA_WIDTH / 4;
    localparam int CW = $clog2(FIELD_CHARS + 1);
    localparam int DW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, PAD, DIGITS, EOL} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         sp_q, sp_d;
    logic [DW-1:0]         dg_q, dg_d;
    logic [DW-1:0]         lz;
    logic                  found;
    logic [CW-1:0]         sp_init;
    logic [3:0]            nib;

    // The lowest nibble is never counted, so an all-zero word still prints one '0'.
    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int i = N - 1; i > 0; i--) begin
            if (!found && InData_DI[4*i +: 4] == 4'h0) lz = lz + DW'(1);
            else found = 1'b1;
        end
        if (SUPPRESS_ZEROS == 0) lz = '0;
    end

    assign sp_init = CW'(FIELD_CHARS - N) + CW'(lz);
    assign nib     = shift_q[DATA_WIDTH-1 -: 4];

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        sp_d    = sp_q;
        dg_d    = dg_q;
        unique case (state_q)
            IDLE: if (InValid_SI) begin
                shift_d = InData_DI << {lz, 2'b00};
                sp_d    = sp_init;
                dg_d    = DW'(N) - lz;
                state_d = (sp_init != '0) ? PAD : DIGITS;
            end
            PAD: if (OutReady_SI) begin
                sp_d    = sp_q - CW'(1);
                state_d = (sp_q == CW'(1)) ? DIGITS : PAD;
            end
            DIGITS: if (OutReady_SI) begin
                shift_d = shift_q << 4;
                dg_d    = dg_q - DW'(1);
                state_d = (dg_q == DW'(1)) ? EOL : DIGITS;
            end
            EOL: if (OutReady_SI) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q <= IDLE;
            shift_q <= '0;
            sp_q    <= '0;
            dg_q    <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            sp_q    <= sp_d;
            dg_q    <= dg_d;
        end
    end

    assign InReady_SO  = (state_q == IDLE);
    assign OutValid_SO = (state_q != IDLE);
    assign Busy_SO     = (state_q != IDLE);

    always_comb begin
        OutChar_DO = (state_q == PAD)    ? 8'h20 :
                     (state_q == EOL)    ? EOL_CHAR :
                     (state_q == DIGITS) ? ((nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h57 + {4'h0, nib}) :
                                           8'h00;
    end
endmodule

// File: tb/tb_aes_hex_line_formatter.sv
// tb_aes_hex_line_formatter: scoreboard bench comparing emitted characters with a text-line model.
module tb_aes_hex_line_formatter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] d1 = '0, d2 = '0;
    logic         v1 = 1'b0, v2 = 1'b0;
    logic         ir1, ir2, ov1, ov2, bz1, bz2;
    logic [7:0]   oc1, oc2;
    logic         or1 = 1'b1;
    logic         or2 = 1'b1;
    logic         rnd_mode = 1'b0;
    logic [7:0]   q1[$], q2[$];
    int           nt = 0, nf = 0, ntx = 0;
    logic         stall_prev = 1'b0;
    logic [7:0]   prev_c = '0;

    always #5 clk = ~clk;

    aes_hex_line_formatter dut1 (
        .Clk_CI(clk), .Rst_RI(rst), .InData_DI(d1), .InValid_SI(v1), .InReady_SO(ir1),
        .OutChar_DO(oc1), .OutValid_SO(ov1), .OutReady_SI(or1), .Busy_SO(bz1));

    aes_hex_line_formatter #(.FIELD_CHARS(36), .SUPPRESS_ZEROS(0)) dut2 (
        .Clk_CI(clk), .Rst_RI(rst), .InData_DI(d2), .InValid_SI(v2), .InReady_SO(ir2),
        .OutChar_DO(oc2), .OutValid_SO(ov2), .OutReady_SI(or2), .Busy_SO(bz2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nt++;
        assert (got === exp) else begin
            nf++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 10) ? 8'h30 + 8'(n) : 8'h61 + 8'(n) - 8'd10;
    endfunction

    task automatic model(input logic [127:0] w, input int fc, input bit sz, input bit which);
        int lz = 0;
        logic [7:0] c;
        if (sz) while (lz < 31 && w[127-4*lz -: 4] == 4'h0) lz++;
        for (int i = 0; i < fc - 32 + lz; i++) if (which) q2.push_back(8'h20); else q1.push_back(8'h20);
        for (int i = lz; i < 32; i++) begin
            c = hexc(w[127-4*i -: 4]);
            if (which) q2.push_back(c); else q1.push_back(c);
        end
        if (which) q2.push_back(8'h0A); else q1.push_back(8'h0A);
    endtask

    always @(posedge clk) begin
        #1;
        or1 = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst && stall_prev) check("stall_stable", {24'h0, oc1}, {24'h0, prev_c});
        stall_prev = !rst && ov1 && !or1;
        prev_c = oc1;
        if (!rst && ov1 && or1) begin
            check("queue1_nonempty", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) check("char1", {24'h0, oc1}, {24'h0, q1.pop_front()});
            ntx++;
        end
        if (!rst && ov2 && or2) begin
            check("queue2_nonempty", 32'(q2.size() > 0), 32'd1);
            if (q2.size() > 0) check("char2", {24'h0, oc2}, {24'h0, q2.pop_front()});
        end
    end

    task automatic send(input logic [127:0] w, input bit which);
        bit ok = 1'b0;
        @(posedge clk); #1;
        if (which) begin d2 = w; v2 = 1'b1; end else begin d1 = w; v1 = 1'b1; end
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            ok = which ? ir2 : ir1;
        end
        check("accept_timeout", 32'(ok), 32'd1);
        if (which) model(w, 36, 1'b0, 1'b1); else model(w, 32, 1'b1, 1'b0);
        @(posedge clk); #1;
        if (which) begin v2 = 1'b0; d2 = ~w; end else begin v1 = 1'b0; d1 = ~w; end
    endtask

    task automatic drain(input bit which);
        bit done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            done = which ? (q2.size() == 0 && !bz2) : (q1.size() == 0 && !bz1);
        end
        check("drain", 32'(done), 32'd1);
    endtask

    initial begin
        int cnt;
        bit ok;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(ir1), 32'd1);
        check("rst_out_valid", 32'(ov1), 32'd0);
        check("rst_out_char", {24'h0, oc1}, 32'h0);
        check("rst_busy", 32'(bz1), 32'd0);
        check("rst_in_ready2", 32'(ir2), 32'd1);

        send(128'h0000BEEF, 1'b0);
        for (int i = 0; i < 33; i++) begin
            if (i == 0) begin v1 = 1'b1; d1 = 128'hDEAD; end
            if (i == 20) v1 = 1'b0;
            @(negedge clk);
            check("consecutive_valid", 32'(ov1), 32'd1);
        end
        @(negedge clk);
        check("bubble_idle", 32'(ov1), 32'd0);
        drain(1'b0);

        send(128'h0, 1'b0);
        drain(1'b0);
        send(128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0);
        drain(1'b0);

        rnd_mode = 1'b1;
        send(128'h0000BEEF, 1'b0);
        send(128'h0, 1'b0);
        send(128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0);
        drain(1'b0);
        rnd_mode = 1'b0;
        @(posedge clk);

        send(128'h3925841D02DC09FBDC118597196A0B32, 1'b0);
        cnt = 0;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (ir1) ok = 1'b1; else cnt++;
        end
        check("accept_to_idle_cycles", 32'(cnt + 1), 32'd34);
        drain(1'b0);

        ntx = 0;
        send(128'h3925841D02DC09FBDC118597196A0B32, 1'b0);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(posedge clk);
            ok = (ntx >= 5);
        end
        check("reach_5th_char", 32'(ok), 32'd1);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 32'(ov1), 32'd0);
        check("abort_in_ready", 32'(ir1), 32'd1);
        check("abort_out_char", {24'h0, oc1}, 32'h0);
        q1.delete();
        send(128'hCAFE, 1'b0);
        drain(1'b0);

        send(128'h1, 1'b1);
        drain(1'b1);

        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end
endmodule
